// File: rtl/proc_control_fsm.sv
// proc_control_fsm: multi-cycle control unit sequencing fetch/decode/execute/memory/writeback
module proc_control_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic [31:0] ctrl,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        bus_err
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  typedef enum logic [2:0] {
    S_RST = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd7
  } state_t;
  state_t cur, nxt;
  logic [CW-1:0] wcnt;
  logic [5:0] op, fn;
  logic [3:0] alu, op2;
  logic [2:0] wa, wd;
  logic [31:0] dp;
  logic taken, legal, wr, mem, rd, spl, jmp, jr, beq, bne, r1z, op1, ma1, md1, wait_st, tmo;
  logic unused_bits;
  assign op = instruction[31:26];
  assign fn = instruction[5:0];
  assign unused_bits = ^instruction[25:6];
  assign state = cur;
  assign wait_st = cur == S_FETCH || cur == S_MEM;
  assign tmo = !mem_rdy && wcnt == CW'(MEM_WAIT_MAX - 1);
  assign dp = {3'b000, md1, 1'b0, ma1, alu, op2, op1, 1'b0, wd, wa, 2'b00, r1z, 7'd0};
  // instruction decode: datapath selects plus per-instruction sequencing flags
  always_comb begin
    legal = 1'b1; wr = 1'b0; mem = 1'b0; rd = 1'b0; spl = 1'b0; jmp = 1'b0; jr = 1'b0;
    beq = 1'b0; bne = 1'b0; r1z = 1'b0; op1 = 1'b0; ma1 = 1'b0; md1 = 1'b0;
    alu = 4'd0; op2 = 4'b0000; wa = 3'b101; wd = 3'b100;
    case (op)
      6'h00: begin
        wr = 1'b1; wa = 3'b100; op2 = 4'b1000;
        case (fn)
          6'h20: alu = 4'd1;
          6'h22: alu = 4'd2;
          6'h2c: alu = 4'd3;
          6'h02: begin alu = 4'd4; op2 = 4'b0101; end
          6'h01: begin alu = 4'd5; op2 = 4'b0101; end
          6'h24: alu = 4'd6;
          6'h25: alu = 4'd7;
          6'h27: alu = 4'd8;
          6'h2a: alu = 4'd9;
          6'h08: begin jr = 1'b1; wr = 1'b0; end
          default: begin legal = 1'b0; wr = 1'b0; end
        endcase
      end
      6'h08: begin wr = 1'b1; alu = 4'd1; op2 = 4'b0010; end
      6'h1d: begin wr = 1'b1; alu = 4'd3; op2 = 4'b0010; end
      6'h0a: begin wr = 1'b1; alu = 4'd9; op2 = 4'b0010; end
      6'h0c: begin wr = 1'b1; alu = 4'd6; end
      6'h0d: begin wr = 1'b1; alu = 4'd7; end
      6'h0f: begin wr = 1'b1; wd = 3'b110; r1z = 1'b1; end
      6'h04: begin beq = 1'b1; alu = 4'd2; op2 = 4'b1000; end
      6'h05: begin bne = 1'b1; alu = 4'd2; op2 = 4'b1000; end
      6'h23: begin wr = 1'b1; mem = 1'b1; rd = 1'b1; alu = 4'd1; op2 = 4'b0010; wd = 3'b101; end
      6'h2b: begin mem = 1'b1; alu = 4'd1; op2 = 4'b0010; md1 = 1'b1; end
      6'h02: jmp = 1'b1;
      6'h03: begin jmp = 1'b1; wr = 1'b1; wa = 3'b010; wd = 3'b000; end
      6'h1b: begin mem = 1'b1; spl = 1'b1; op1 = 1'b1; op2 = 4'b0100; alu = 4'd2; ma1 = 1'b1; r1z = 1'b1; end
      6'h1c: begin mem = 1'b1; rd = 1'b1; spl = 1'b1; op1 = 1'b1; op2 = 4'b0100; alu = 4'd1; ma1 = 1'b1; wr = 1'b1; wa = 3'b000; wd = 3'b101; end
      default: legal = 1'b0;
    endcase
  end
  // next state and Moore control vector; RST_S and HALT leave ctrl at zero
  always_comb begin
    nxt = cur;
    ctrl = 32'd0;
    case (cur)
      S_RST: nxt = S_FETCH;
      S_FETCH: begin
        nxt = mem_rdy ? S_DECODE : tmo ? S_HALT : S_FETCH;
        ctrl[5] = 1'b1; ctrl[27] = 1'b1; ctrl[4] = mem_rdy;
      end
      S_DECODE: begin
        nxt = legal ? S_EXEC : S_HALT;
        ctrl[8] = 1'b1; ctrl[7] = r1z;
      end
      S_EXEC: begin
        nxt = mem ? S_MEM : S_WB;
        ctrl = dp; ctrl[8] = 1'b1;
      end
      S_MEM: begin
        nxt = mem_rdy ? S_WB : tmo ? S_HALT : S_MEM;
        ctrl = dp; ctrl[5] = rd; ctrl[6] = !rd;
      end
      S_WB: begin
        nxt = S_FETCH;
        ctrl = dp; ctrl[0] = 1'b1; ctrl[1] = !jr; ctrl[2] = taken; ctrl[3] = !jmp; ctrl[9] = wr; ctrl[16] = spl;
      end
      default: nxt = cur;
    endcase
  end
  // state, memory wait counter, branch-taken latch and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_RST; wcnt <= '0; taken <= 1'b0; illegal <= 1'b0; bus_err <= 1'b0;
    end else begin
      cur <= nxt;
      wcnt <= (nxt != cur) ? '0 : wcnt + CW'(wait_st && !mem_rdy);
      taken <= (cur == S_EXEC) ? (beq && zero) || (bne && !zero) : taken;
      illegal <= illegal || (cur == S_DECODE && !legal);
      bus_err <= bus_err || (wait_st && tmo);
    end
  end
endmodule

// File: tb/tb_proc_control_fsm.sv
// tb_proc_control_fsm: directed checks of sequencing, waits, branches, errors and reset abort
module tb_proc_control_fsm;
  logic clk, rst_n, zero, mem_rdy, illegal, bus_err;
  logic [31:0] instruction, ctrl;
  logic [2:0] state;
  int n_chk, n_fail;
  localparam logic [31:0] ADD = 32'h00221820, LW = 32'h8C240000, SW = 32'hAC240000,
    BEQ = 32'h10220005, BNE = 32'h14220005, JAL = 32'h0C00000A, PUSH = 32'h6C000000, BAD = 32'hFC000000;
  proc_control_fsm dut (.clk(clk), .rst_n(rst_n), .instruction(instruction), .zero(zero),
    .mem_rdy(mem_rdy), .ctrl(ctrl), .state(state), .illegal(illegal), .bus_err(bus_err));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; zero = 1'b0; mem_rdy = 1'b1; instruction = ADD;
    step(); step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", ctrl, 32'd0);
    chk("rst_flags", {30'd0, illegal, bus_err}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("add_fetch_state", 32'(state), 32'd1);
    chk("add_fetch_memr_irld_masel2", {29'd0, ctrl[27], ctrl[5], ctrl[4]}, 32'd7);
    step();
    chk("add_decode_state", 32'(state), 32'd2);
    chk("add_decode_regr", 32'(ctrl[8]), 32'd1);
    step();
    chk("add_exec_state", 32'(state), 32'd3);
    chk("add_exec_alu", 32'(ctrl[25:22]), 32'd1);
    step();
    chk("add_wb_state", 32'(state), 32'd5);
    chk("add_wb_regw_pcld_pcsel1", {29'd0, ctrl[9], ctrl[1], ctrl[0]}, 32'd7);
    chk("add_wb_pcsel2", 32'(ctrl[2]), 32'd0);
    step();
    chk("add_back_fetch", 32'(state), 32'd1);
    instruction = LW;
    step(); step();
    chk("lw_exec_state", 32'(state), 32'd3);
    mem_rdy = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("lw_mem_state", 32'(state), 32'd4);
      chk("lw_mem_memr", {30'd0, ctrl[6], ctrl[5]}, 32'd1);
      if (i == 3) mem_rdy = 1'b1;
      step();
    end
    chk("lw_wb_state", 32'(state), 32'd5);
    chk("lw_wb_regw", 32'(ctrl[9]), 32'd1);
    chk("lw_no_buserr", 32'(bus_err), 32'd0);
    step();
    instruction = BEQ; zero = 1'b1;
    step(); step(); step();
    chk("beq_wb_state", 32'(state), 32'd5);
    chk("beq_taken_pcsel2", 32'(ctrl[2]), 32'd1);
    step();
    instruction = BNE;
    step(); step(); step();
    chk("bne_wb_state", 32'(state), 32'd5);
    chk("bne_not_taken_pcsel2", 32'(ctrl[2]), 32'd0);
    step();
    zero = 1'b0; instruction = JAL;
    step(); step(); step();
    chk("jal_wb_state", 32'(state), 32'd5);
    chk("jal_wb_pcsel3_regw_pcld", {29'd0, ctrl[3], ctrl[9], ctrl[0]}, 32'd3);
    step();
    instruction = PUSH;
    step(); step(); step();
    chk("push_mem_state", 32'(state), 32'd4);
    chk("push_mem_memw_masel1", {29'd0, ctrl[26], ctrl[6], ctrl[5]}, 32'd6);
    step();
    chk("push_wb_state", 32'(state), 32'd5);
    chk("push_wb_spld_regw", {30'd0, ctrl[16], ctrl[9]}, 32'd2);
    step();
    instruction = BAD;
    step();
    chk("bad_decode_state", 32'(state), 32'd2);
    step();
    for (int i = 0; i < 100; i++) begin
      mem_rdy = i[0];
      chk("halt_ctrl", ctrl, 32'd0);
      chk("halt_flags_state", {27'd0, illegal, bus_err, state}, 32'h17);
      step();
    end
    rst_n = 1'b0; mem_rdy = 1'b0;
    #1;
    chk("rst_pulse_state", 32'(state), 32'd0);
    chk("rst_pulse_flags_ctrl", {30'd0, illegal, bus_err} | ctrl, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      chk("to_fetch_state", 32'(state), 32'd1);
      chk("to_no_pcld", 32'(ctrl[0]), 32'd0);
      step();
    end
    chk("to_halt_state", 32'(state), 32'd7);
    chk("to_buserr", {30'd0, illegal, bus_err}, 32'd1);
    chk("to_halt_ctrl", ctrl, 32'd0);
    rst_n = 1'b0;
    #1;
    step();
    mem_rdy = 1'b1; instruction = SW; rst_n = 1'b1;
    step(); step(); step();
    mem_rdy = 1'b0;
    step();
    chk("sw_mem_state", 32'(state), 32'd4);
    chk("sw_mem_memw", {30'd0, ctrl[6], ctrl[5]}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("sw_abort_ctrl", ctrl, 32'd0);
    chk("sw_abort_state", 32'(state), 32'd0);
    mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sw_abort_no_wb", {30'd0, ctrl[9], ctrl[0]}, 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("sw_restart_fetch", 32'(state), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
